// File: rtl/bit_decpt.sv
// bit_decpt: loadable down-counter with a one-cycle terminal-count pulse
// Ports: clk      - clock, all state updates on posedge
//        reset    - asynchronous, active-low reset
//        activate - count enable, ignored while IDLE
//        load     - synchronous load strobe, wins over activate
//        load_val - value captured on load
//        cpt      - registered current count
//        zero     - combinational cpt == 0
//        tc       - registered one-cycle terminal-count pulse
//        busy     - high while in state RUN
// Option: define BIT_DECPT_AUTORELOAD_EN to reload the last loaded value on the
//         terminal step and keep running instead of stopping at zero.
module bit_decpt #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             activate,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cpt,
    output logic             zero,
    output logic             tc,
    output logic             busy
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nxt;
    logic [WIDTH-1:0] cpt_nxt;
    logic tc_nxt;
`ifdef BIT_DECPT_AUTORELOAD_EN
    logic [WIDTH-1:0] rld, rld_nxt;
`endif
    assign zero = cpt == '0;
    assign busy = state == RUN;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cpt   <= '0;
            tc    <= 1'b0;
`ifdef BIT_DECPT_AUTORELOAD_EN
            rld   <= '0;
`endif
        end else begin
            state <= state_nxt;
            cpt   <= cpt_nxt;
            tc    <= tc_nxt;
`ifdef BIT_DECPT_AUTORELOAD_EN
            rld   <= rld_nxt;
`endif
        end
    end
    always_comb begin
        state_nxt = state;
        cpt_nxt   = cpt;
        tc_nxt    = 1'b0;
`ifdef BIT_DECPT_AUTORELOAD_EN
        rld_nxt   = rld;
`endif
        if (load) begin
            cpt_nxt   = load_val;
            state_nxt = load_val != '0 ? RUN : IDLE;
`ifdef BIT_DECPT_AUTORELOAD_EN
            rld_nxt   = load_val;
`endif
        end else if (state == RUN && activate) begin
            if (cpt == WIDTH'(1)) begin
                tc_nxt = 1'b1;
`ifdef BIT_DECPT_AUTORELOAD_EN
                cpt_nxt = rld;
`else
                cpt_nxt   = '0;
                state_nxt = IDLE;
`endif
            end else if (cpt != '0) begin
                // the zero guard keeps the count from ever wrapping
                cpt_nxt = cpt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bit_decpt.sv
// tb_bit_decpt: directed scoreboard bench for bit_decpt
module tb_bit_decpt;
    localparam int W = 3;
`ifdef BIT_DECPT_AUTORELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic activate = 1'b0;
    logic load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] cpt;
    logic zero, tc, busy;
    int total = 0;
    int bad = 0;
    typedef struct {
        string tag;
        logic [W-1:0] cpt;
        logic tc;
        logic busy;
    } exp_t;
    exp_t q[$];
    bit_decpt #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .activate(activate), .load(load),
        .load_val(load_val), .cpt(cpt), .zero(zero), .tc(tc), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic check_out(input exp_t e);
        chk({e.tag, ".cpt"}, 16'(cpt), 16'(e.cpt));
        chk({e.tag, ".tc"}, 16'(tc), 16'(e.tc));
        chk({e.tag, ".busy"}, 16'(busy), 16'(e.busy));
        chk({e.tag, ".zero"}, 16'(zero), 16'(e.cpt == '0));
    endtask
    task automatic step(input string tag, input logic act, input logic ld, input logic [W-1:0] lv,
                        input logic [W-1:0] ec, input logic etc, input logic eb);
        exp_t e;
        activate = act;
        load = ld;
        load_val = lv;
        e.tag = tag;
        e.cpt = ec;
        e.tc = etc;
        e.busy = eb;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=empty expected=entry", tag);
        end else begin
            check_out(q.pop_front());
        end
        activate = 1'b0;
        load = 1'b0;
    endtask
    initial begin
        exp_t r;
        #3;
        r.tag = "por"; r.cpt = '0; r.tc = 1'b0; r.busy = 1'b0;
        check_out(r);
        @(posedge clk);
        #1;
        reset = 1'b1;
        // reset asserted mid-count takes effect without a clock edge
        step("t1_ld6", 0, 1, 3'd6, 3'd6, 0, 1);
        step("t1_a1", 1, 0, 3'd0, 3'd5, 0, 1);
        step("t1_a2", 1, 0, 3'd0, 3'd4, 0, 1);
        #2;
        reset = 1'b0;
        #1;
        r.tag = "t1_async"; r.cpt = '0; r.tc = 1'b0; r.busy = 1'b0;
        check_out(r);
        step("t1_held", 1, 0, 3'd0, 3'd0, 0, 0);
        reset = 1'b1;
        step("t1_idle1", 1, 0, 3'd0, 3'd0, 0, 0);
        step("t1_idle2", 1, 0, 3'd0, 3'd0, 0, 0);
        // load 5, activate held high
        step("t2_ld5", 0, 1, 3'd5, 3'd5, 0, 1);
        step("t2_c4", 1, 0, 3'd0, 3'd4, 0, 1);
        step("t2_c3", 1, 0, 3'd0, 3'd3, 0, 1);
        step("t2_c2", 1, 0, 3'd0, 3'd2, 0, 1);
        step("t2_c1", 1, 0, 3'd0, 3'd1, 0, 1);
        step("t2_term", 1, 0, 3'd0, AR ? 3'd5 : 3'd0, 1, AR);
        step("t2_after", 0, 0, 3'd0, AR ? 3'd5 : 3'd0, 0, AR);
        // activate toggled 1,0,0,1,1,1
        step("t3_ld4", 0, 1, 3'd4, 3'd4, 0, 1);
        step("t3_s1", 1, 0, 3'd0, 3'd3, 0, 1);
        step("t3_s2", 0, 0, 3'd0, 3'd3, 0, 1);
        step("t3_s3", 0, 0, 3'd0, 3'd3, 0, 1);
        step("t3_s4", 1, 0, 3'd0, 3'd2, 0, 1);
        step("t3_s5", 1, 0, 3'd0, 3'd1, 0, 1);
        step("t3_term", 1, 0, 3'd0, AR ? 3'd4 : 3'd0, 1, AR);
        // reload mid-count restarts, load has priority over activate
        step("t4_ld6", 0, 1, 3'd6, 3'd6, 0, 1);
        step("t4_a1", 1, 0, 3'd0, 3'd5, 0, 1);
        step("t4_a2", 1, 0, 3'd0, 3'd4, 0, 1);
        step("t4_ld2", 1, 1, 3'd2, 3'd2, 0, 1);
        step("t4_a3", 1, 0, 3'd0, 3'd1, 0, 1);
        step("t4_term", 1, 0, 3'd0, AR ? 3'd2 : 3'd0, 1, AR);
        // load of zero goes idle, activate ignored
        step("t5_ld0", 1, 1, 3'd0, 3'd0, 0, 0);
        step("t5_a1", 1, 0, 3'd0, 3'd0, 0, 0);
        step("t5_a2", 1, 0, 3'd0, 3'd0, 0, 0);
        step("t5_ld1", 1, 1, 3'd1, 3'd1, 0, 1);
        step("t5_term1", 1, 0, 3'd0, AR ? 3'd1 : 3'd0, 1, AR);
`ifdef BIT_DECPT_AUTORELOAD_EN
        step("t6_ld3", 0, 1, 3'd3, 3'd3, 0, 1);
        step("t6_c2", 1, 0, 3'd0, 3'd2, 0, 1);
        step("t6_c1", 1, 0, 3'd0, 3'd1, 0, 1);
        step("t6_r1", 1, 0, 3'd0, 3'd3, 1, 1);
        step("t6_c2b", 1, 0, 3'd0, 3'd2, 0, 1);
        step("t6_c1b", 1, 0, 3'd0, 3'd1, 0, 1);
        step("t6_r2", 1, 0, 3'd0, 3'd3, 1, 1);
        step("t6_ld0", 0, 1, 3'd0, 3'd0, 0, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
